// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory arbiter: size defaults, FSM state
// encoding and requester IDs.
package mips_pkg;

    localparam int AW_DEF           = 10;
    localparam int DW_DEF           = 32;
    localparam int STARVE_LIMIT_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ID_LD   = 2'd0,
        ID_DM   = 2'd1,
        ID_IF   = 2'd2,
        ID_NONE = 2'd3
    } req_id_t;

    // One-hot {ld, dm, if} pattern used for both the grant and ack triples.
    function automatic logic [2:0] id_onehot(input req_id_t id);
        logic [2:0] oh;
        case (id)
            ID_LD:   oh = 3'b100;
            ID_DM:   oh = 3'b010;
            ID_IF:   oh = 3'b001;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/mips_prio_pick.sv
// Three-way fixed-priority picker (loader > data > fetch); the boost input
// lets a starved fetch jump ahead of data but never ahead of the loader.
module mips_prio_pick
    import mips_pkg::*;
(
    input  logic    ld_req,
    input  logic    dm_req,
    input  logic    if_req,
    input  logic    if_boost,
    output logic    valid,
    output req_id_t id
);

    // Winner selection
    always_comb begin
        valid = 1'b1;
        id    = ID_NONE;
        if (ld_req) begin
            id = ID_LD;
        end else if (if_boost && if_req) begin
            id = ID_IF;
        end else if (dm_req) begin
            id = ID_DM;
        end else if (if_req) begin
            id = ID_IF;
        end else begin
            valid = 1'b0;
            id    = ID_NONE;
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbitrates the loader, MEM-stage data and instruction-fetch ports onto one
// single-port synchronous-read memory, one access every two cycles at best.
module mips_mem_arbiter
    import mips_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_ack,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_ack,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_ack,
    input  logic          halted,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int           CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    state_t        state_r;
    req_id_t       cur_id_r;
    logic          cur_we_r;
    logic [CW-1:0] starve_cnt_r;

    logic          fetch_wait_s;
    logic          arb_s;
    logic          boost_s;
    logic          pick_valid_s;
    req_id_t       pick_id_s;
    logic          win_we_s;
    logic [AW-1:0] win_addr_s;
    logic [DW-1:0] win_wdata_s;

    assign fetch_wait_s = if_req && !halted;
    assign arb_s        = (state_r == ST_IDLE) || (state_r == ST_RESP);
    assign boost_s      = (starve_cnt_r >= LIMIT);

    mips_prio_pick u_pick (
        .ld_req   (ld_req),
        .dm_req   (dm_req),
        .if_req   (fetch_wait_s),
        .if_boost (boost_s),
        .valid    (pick_valid_s),
        .id       (pick_id_s)
    );

    // Route the winning requester's command toward the memory registers
    always_comb begin
        win_we_s    = 1'b0;
        win_addr_s  = '0;
        win_wdata_s = '0;
        case (pick_id_s)
            ID_LD: begin
                win_we_s    = ld_we;
                win_addr_s  = ld_addr;
                win_wdata_s = ld_wdata;
            end
            ID_DM: begin
                win_we_s    = dm_we;
                win_addr_s  = dm_addr;
                win_wdata_s = dm_wdata;
            end
            ID_IF: begin
                win_we_s    = 1'b0;
                win_addr_s  = if_addr;
                win_wdata_s = '0;
            end
            default: begin
                win_we_s    = 1'b0;
                win_addr_s  = '0;
                win_wdata_s = '0;
            end
        endcase
    end

    // Arbitration FSM with registered grant, ack and memory command outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cur_id_r  <= ID_NONE;
            cur_we_r  <= 1'b0;
            ld_gnt    <= 1'b0;
            dm_gnt    <= 1'b0;
            if_gnt    <= 1'b0;
            ld_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_ack    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            ld_gnt <= 1'b0;
            dm_gnt <= 1'b0;
            if_gnt <= 1'b0;
            ld_ack <= 1'b0;
            dm_ack <= 1'b0;
            if_ack <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            case (state_r)
                ST_IDLE, ST_RESP: begin
                    if (pick_valid_s) begin
                        state_r                  <= ST_GRANT;
                        cur_id_r                 <= pick_id_s;
                        cur_we_r                 <= win_we_s;
                        {ld_gnt, dm_gnt, if_gnt} <= id_onehot(pick_id_s);
                        mem_en                   <= 1'b1;
                        mem_we                   <= win_we_s;
                        mem_addr                 <= win_addr_s;
                        mem_wdata                <= win_wdata_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    state_r                  <= ST_RESP;
                    {ld_ack, dm_ack, if_ack} <= id_onehot(cur_id_r);
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Starvation counter: counts data grants that overtook a waiting fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_r <= '0;
        end else if (!fetch_wait_s) begin
            starve_cnt_r <= '0;
        end else if (arb_s && pick_valid_s) begin
            if (pick_id_s == ID_IF) begin
                starve_cnt_r <= '0;
            end else if (pick_id_s == ID_DM && !boost_s) begin
                starve_cnt_r <= starve_cnt_r + CW'(1);
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Read data comes straight from the memory's registered output during RESP
    always_comb begin
        if (state_r == ST_RESP && !cur_we_r) begin
            rdata = mem_rdata;
        end else begin
            rdata = '0;
        end
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: directed vector table plus
// hand-written multi-cycle sequences, against a behavioural 1024x32 memory.
module tb_mips_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_req, ld_we, dm_req, dm_we, if_req, halted;
    logic [9:0]  ld_addr, dm_addr, if_addr;
    logic [31:0] ld_wdata, dm_wdata;
    logic        ld_gnt, ld_ack, dm_gnt, dm_ack, if_gnt, if_ack;
    logic [31:0] rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem [1024];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mips_mem_arbiter #(.AW(10), .DW(32), .STARVE_LIMIT(3)) dut (
        .clk(clk), .reset(reset),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_ack(ld_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_ack(dm_ack),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_ack(if_ack),
        .halted(halted), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Single-port memory with one-cycle synchronous read
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct packed {
        logic        ld_req;  logic ld_we;  logic [9:0] ld_addr; logic [31:0] ld_wdata;
        logic        dm_req;  logic dm_we;  logic [9:0] dm_addr; logic [31:0] dm_wdata;
        logic        if_req;  logic [9:0] if_addr; logic halted;
        logic [2:0]  exp_gnt; logic exp_we; logic [9:0] exp_addr;
        logic [31:0] exp_wdata; logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drop_all();
        ld_req = 1'b0; dm_req = 1'b0; if_req = 1'b0; halted = 1'b0;
    endtask

    function automatic logic [7:0] ctl_bits();
        return {ld_gnt, ld_ack, dm_gnt, dm_ack, if_gnt, if_ack, mem_en, mem_we};
    endfunction

    initial begin
        logic [2:0]  exp_g [7];
        logic [2:0]  exp_a [7];
        logic [31:0] exp_r [7];
        int          g;

        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem_rdata = 32'd0;
        reset = 1'b1;
        drop_all();
        ld_we = 1'b0; dm_we = 1'b0;
        ld_addr = 10'd0; dm_addr = 10'd0; if_addr = 10'd0;
        ld_wdata = 32'd0; dm_wdata = 32'd0;

        //                ld: req we addr wdata              dm: req we addr wdata        if: req addr halted  exp: gnt we addr wdata rdata
        vecs[0]  = '{1'b1,1'b1,10'd0,32'h2801000a,    1'b0,1'b0,10'd0,32'd0,       1'b0,10'd0,1'b0,  3'b100,1'b1,10'd0,32'h2801000a,32'd0};
        vecs[1]  = '{1'b0,1'b0,10'd0,32'd0,           1'b0,1'b0,10'd0,32'd0,       1'b1,10'd0,1'b0,  3'b001,1'b0,10'd0,32'd0,32'h2801000a};
        vecs[2]  = '{1'b0,1'b0,10'd0,32'd0,           1'b1,1'b1,10'd3,32'h19,      1'b0,10'd0,1'b0,  3'b010,1'b1,10'd3,32'h19,32'd0};
        vecs[3]  = '{1'b0,1'b0,10'd0,32'd0,           1'b1,1'b0,10'd3,32'd0,       1'b0,10'd0,1'b0,  3'b010,1'b0,10'd3,32'd0,32'h19};
        vecs[4]  = '{1'b1,1'b0,10'd3,32'd0,           1'b1,1'b1,10'd7,32'h55,      1'b1,10'd0,1'b0,  3'b100,1'b0,10'd3,32'd0,32'h19};
        vecs[5]  = '{1'b0,1'b0,10'd0,32'd0,           1'b1,1'b1,10'd7,32'h55,      1'b1,10'd0,1'b0,  3'b010,1'b1,10'd7,32'h55,32'd0};
        vecs[6]  = '{1'b0,1'b0,10'd0,32'd0,           1'b0,1'b0,10'd0,32'd0,       1'b1,10'd7,1'b1,  3'b000,1'b0,10'd0,32'd0,32'd0};
        vecs[7]  = '{1'b0,1'b0,10'd0,32'd0,           1'b0,1'b0,10'd0,32'd0,       1'b1,10'd7,1'b0,  3'b001,1'b0,10'd7,32'd0,32'h55};
        vecs[8]  = '{1'b0,1'b0,10'd0,32'd0,           1'b1,1'b0,10'd0,32'd0,       1'b1,10'd5,1'b1,  3'b010,1'b0,10'd0,32'd0,32'h2801000a};
        vecs[9]  = '{1'b1,1'b1,10'd1023,32'hffffffff, 1'b0,1'b0,10'd0,32'd0,       1'b0,10'd0,1'b0,  3'b100,1'b1,10'd1023,32'hffffffff,32'd0};
        vecs[10] = '{1'b0,1'b0,10'd0,32'd0,           1'b1,1'b0,10'd1023,32'd0,    1'b0,10'd0,1'b0,  3'b010,1'b0,10'd1023,32'd0,32'hffffffff};

        @(negedge clk);
        step(); step();
        chk("reset_ctl", 64'(ctl_bits()), 64'd0);
        chk("reset_addr", 64'(mem_addr), 64'd0);
        chk("reset_wdata", 64'(mem_wdata), 64'd0);
        chk("reset_rdata", 64'(rdata), 64'd0);
        reset = 1'b0;

        // Directed vectors: sample, GRANT, RESP, back to IDLE
        for (int i = 0; i < 11; i++) begin
            ld_req = vecs[i].ld_req; ld_we = vecs[i].ld_we;
            ld_addr = vecs[i].ld_addr; ld_wdata = vecs[i].ld_wdata;
            dm_req = vecs[i].dm_req; dm_we = vecs[i].dm_we;
            dm_addr = vecs[i].dm_addr; dm_wdata = vecs[i].dm_wdata;
            if_req = vecs[i].if_req; if_addr = vecs[i].if_addr; halted = vecs[i].halted;
            step();
            chk($sformatf("v%0d_gnt", i), 64'({ld_gnt, dm_gnt, if_gnt}), 64'(vecs[i].exp_gnt));
            chk($sformatf("v%0d_en", i), 64'(mem_en), 64'(vecs[i].exp_gnt != 3'b000));
            if (vecs[i].exp_gnt != 3'b000) begin
                chk($sformatf("v%0d_we", i), 64'(mem_we), 64'(vecs[i].exp_we));
                chk($sformatf("v%0d_addr", i), 64'(mem_addr), 64'(vecs[i].exp_addr));
                chk($sformatf("v%0d_wdata", i), 64'(mem_wdata), 64'(vecs[i].exp_wdata));
            end
            drop_all();
            step();
            chk($sformatf("v%0d_ack", i), 64'({ld_ack, dm_ack, if_ack}), 64'(vecs[i].exp_gnt));
            chk($sformatf("v%0d_rdata", i), 64'(rdata), 64'(vecs[i].exp_rdata));
            step();
            chk($sformatf("v%0d_idle", i), 64'({ctl_bits(), rdata}), 64'd0);
        end

        // All three request together: LD, DM, IF granted on cycles 1, 3, 5
        for (int k = 0; k < 7; k++) begin
            exp_g[k] = 3'b000; exp_a[k] = 3'b000; exp_r[k] = 32'd0;
        end
        exp_g[1] = 3'b100; exp_g[3] = 3'b010; exp_g[5] = 3'b001;
        exp_a[2] = 3'b100; exp_a[4] = 3'b010; exp_a[6] = 3'b001;
        exp_r[2] = 32'h2801000a; exp_r[4] = 32'h19; exp_r[6] = 32'h55;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 10'd0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd3;
        if_req = 1'b1; if_addr = 10'd7;
        for (int k = 1; k < 7; k++) begin
            step();
            chk($sformatf("order_gnt_c%0d", k), 64'({ld_gnt, dm_gnt, if_gnt}), 64'(exp_g[k]));
            chk($sformatf("order_ack_c%0d", k), 64'({ld_ack, dm_ack, if_ack}), 64'(exp_a[k]));
            chk($sformatf("order_rdata_c%0d", k), 64'(rdata), 64'(exp_r[k]));
            if (ld_gnt) ld_req = 1'b0;
            if (dm_gnt) dm_req = 1'b0;
            if (if_gnt) if_req = 1'b0;
        end
        drop_all();
        step(); step();

        // Continuous data traffic with a waiting fetch: D,D,D,I repeating
        g = 0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd3;
        if_req = 1'b1; if_addr = 10'd7;
        for (int k = 0; k < 16; k++) begin
            step();
            if (dm_gnt || if_gnt) begin
                chk($sformatf("starve_g%0d", g), 64'({dm_gnt, if_gnt}),
                    64'(((g % 4) == 3) ? 2'b01 : 2'b10));
                g++;
            end
        end
        chk("starve_count", 64'(g), 64'd8);
        drop_all();
        step(); step(); step();

        // Halted blocks fetch; a halt raised during the fetch GRANT does not cancel it
        halted = 1'b1; if_req = 1'b1; if_addr = 10'd0;
        for (int k = 0; k < 20; k++) begin
            step();
            chk($sformatf("halt_nognt_c%0d", k), 64'({if_gnt, mem_en}), 64'd0);
        end
        halted = 1'b0;
        step();
        chk("unhalt_gnt", 64'(if_gnt), 64'd1);
        if_req = 1'b0; halted = 1'b1;
        step();
        chk("halt_in_grant_ack", 64'(if_ack), 64'd1);
        chk("halt_in_grant_rdata", 64'(rdata), 64'h2801000a);
        halted = 1'b0;
        step();

        // Reset during an in-flight data read of address 5
        mem[5] = 32'hdeadbeef;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd5;
        step();
        chk("rst_grant_gnt", 64'(dm_gnt), 64'd1);
        dm_req = 1'b0; reset = 1'b1;
        step();
        chk("rst_grant_noack", 64'(dm_ack), 64'd0);
        chk("rst_grant_zero", 64'({ctl_bits(), mem_addr, mem_wdata, rdata}), 64'd0);
        reset = 1'b0;
        dm_req = 1'b1;
        step();
        dm_req = 1'b0;
        step();
        chk("rst_resp_ack", 64'(dm_ack), 64'd1);
        chk("rst_resp_rdata", 64'(rdata), 64'hdeadbeef);
        reset = 1'b1;
        step();
        chk("rst_resp_zero", 64'({ctl_bits(), mem_addr, mem_wdata, rdata}), 64'd0);
        reset = 1'b0;
        step();
        chk("rst_resp_stay_idle", 64'(ctl_bits()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
